// File: rtl/omsp_hmac_msg_feeder_if.sv
// Memory-port and HMAC-command bundle between the message feeder and its neighbours.
interface omsp_hmac_msg_feeder_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_din;
  logic              mem_wr;
  logic [15:0]       mem_dout;
  logic              hmac_start_continue;
  logic              hmac_data_available;
  logic [7:0]        hmac_data_in;
  logic [7:0]        hmac_data_out;
  logic              hmac_busy;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_dout,
    output hmac_start_continue, hmac_data_available, hmac_data_in,
    input  mem_din, hmac_data_out, hmac_busy
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_dout,
    input  hmac_start_continue, hmac_data_available, hmac_data_in,
    output mem_din, hmac_data_out, hmac_busy
  );
endinterface

// File: rtl/omsp_hmac_msg_feeder.sv
// Streams a byte-granular memory region into the HMAC core, finalises it and
// writes the squeezed tag back to memory as little-endian words.
module omsp_hmac_msg_feeder #(
  parameter int ADDR_W    = 16,
  parameter int TAG_BYTES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_start,
  input  logic [ADDR_W-1:0] msg_end,
  input  logic [ADDR_W-1:0] tag_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  omsp_hmac_msg_feeder_if.master bus
);

  localparam int IW = (TAG_BYTES > 2) ? $clog2(TAG_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TAG_BYTES - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CHECK    = 4'd1;
  localparam logic [3:0] S_RD_REQ   = 4'd2;
  localparam logic [3:0] S_RD_WAIT  = 4'd3;
  localparam logic [3:0] S_MSG_CMD  = 4'd4;
  localparam logic [3:0] S_MSG_WAIT = 4'd5;
  localparam logic [3:0] S_FIN_CMD  = 4'd6;
  localparam logic [3:0] S_FIN_WAIT = 4'd7;
  localparam logic [3:0] S_OUT_CMD  = 4'd8;
  localparam logic [3:0] S_OUT_WAIT = 4'd9;
  localparam logic [3:0] S_WR       = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

  logic [3:0]        state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_r;
  logic [ADDR_W-1:0] tag_r;
  logic [15:0]       word_buf;
  logic [IW-1:0]     out_idx;
  logic              guard;
  logic              error_r;

  logic [ADDR_W-1:0] cur_nxt;
  logic              reject;
  logic              accept;
  logic [ADDR_W-1:0] wr_off;

  assign cur_nxt = cur + ADDR_W'(1);
  // msg_end == 0 stands for 2^ADDR_W so a region may run up to the top of memory
  assign reject  = tag_r[0] | ({(end_r == '0), end_r} <= {1'b0, cur});
  assign accept  = start & ((state == S_IDLE) | (state == S_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cur      <= '0;
      end_r    <= '0;
      tag_r    <= '0;
      word_buf <= '0;
      out_idx  <= '0;
      guard    <= 1'b0;
      error_r  <= 1'b0;
    end else if (accept) begin
      cur     <= msg_start;
      end_r   <= msg_end;
      tag_r   <= tag_addr;
      out_idx <= '0;
      error_r <= 1'b0;
      state   <= S_CHECK;
    end else begin
      case (state)
        S_IDLE: ;
        S_CHECK: begin
          if (reject) begin
            error_r <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_RD_REQ;
          end
        end
        S_RD_REQ:  state <= S_RD_WAIT;
        S_RD_WAIT: begin
          word_buf <= bus.mem_din;
          state    <= S_MSG_CMD;
        end
        S_MSG_CMD: if (!bus.hmac_busy) begin
          guard <= 1'b1;
          state <= S_MSG_WAIT;
        end
        S_MSG_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (!bus.hmac_busy) begin
            cur <= cur_nxt;
            if (cur_nxt == end_r)  state <= S_FIN_CMD;
            else if (!cur[0])      state <= S_MSG_CMD;
            else                   state <= S_RD_REQ;
          end
        end
        S_FIN_CMD: if (!bus.hmac_busy) begin
          guard <= 1'b1;
          state <= S_FIN_WAIT;
        end
        S_FIN_WAIT: begin
          if (guard)                 guard <= 1'b0;
          else if (!bus.hmac_busy)   state <= S_OUT_CMD;
        end
        S_OUT_CMD: if (!bus.hmac_busy) begin
          guard <= 1'b1;
          state <= S_OUT_WAIT;
        end
        S_OUT_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (!bus.hmac_busy) begin
            if (!out_idx[0]) begin
              word_buf[7:0] <= bus.hmac_data_out;
              out_idx       <= out_idx + IW'(1);
              state         <= S_OUT_CMD;
            end else begin
              word_buf[15:8] <= bus.hmac_data_out;
              state          <= S_WR;
            end
          end
        end
        S_WR: begin
          if (out_idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            out_idx <= out_idx + IW'(1);
            state   <= S_OUT_CMD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_off    = ADDR_W'(out_idx);
    wr_off[0] = 1'b0;

    busy  = (state != S_IDLE) && (state != S_DONE);
    done  = (state == S_DONE);
    error = error_r;

    bus.mem_rd   = (state == S_RD_REQ);
    bus.mem_wr   = (state == S_WR);
    bus.mem_addr = '0;
    if (state == S_RD_REQ) bus.mem_addr = {cur[ADDR_W-1:1], 1'b0};
    else if (state == S_WR) bus.mem_addr = tag_r + wr_off;
    bus.mem_dout = (state == S_WR) ? word_buf : '0;

    bus.hmac_start_continue = ((state == S_MSG_CMD) || (state == S_FIN_CMD) ||
                               (state == S_OUT_CMD)) && !bus.hmac_busy;
    bus.hmac_data_available = (state == S_MSG_CMD) && !bus.hmac_busy;
    // cur only advances when the command completes, so the byte stays stable
    bus.hmac_data_in = '0;
    if ((state == S_MSG_CMD) || (state == S_MSG_WAIT))
      bus.hmac_data_in = cur[0] ? word_buf[15:8] : word_buf[7:0];
  end

endmodule
